// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes and FSM state encoding for the bit-serial ALU
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_bit_cell.sv
// rtl/alu_bit_cell.sv - combinational 1-bit logic/arithmetic cell
module alu_bit_cell
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [2:0] op,
  output logic       out,
  output logic       cout
);

  logic logic_bit;
  logic sum;
  logic carry;

  // Logic result through a 4:1 mux; op[2] selects the full adder instead.
  // SUB arrives here with b already inverted and cin preset, so it is a plain add.
  always_comb begin
    logic_bit = 1'b0;
    case (op[1:0])
      OP_AND[1:0]: logic_bit = a & b;
      OP_OR[1:0]:  logic_bit = a | b;
      OP_XOR[1:0]: logic_bit = a ^ b;
      default:     logic_bit = ~a;
    endcase
    sum   = a ^ b ^ cin;
    carry = (a & b) | (cin & (a ^ b));
    out   = op[2] ? sum : logic_bit;
    cout  = op[2] ? carry : 1'b0;
  end

endmodule

// File: rtl/alu_serial_seq.sv
// rtl/alu_serial_seq.sv - LSB-first bit-serial sequencer around alu_bit_cell
module alu_serial_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [2:0]       op_r;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             cell_out;
  logic             cell_cout;
  logic [WIDTH-1:0] res_next;
  logic             carry_next;

  alu_bit_cell u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .op   (op_r),
    .out  (cell_out),
    .cout (cell_cout)
  );

  // New bit enters at the MSB so after WIDTH shifts the first bit sits at bit 0.
  // Carry only advances for arithmetic ops; logic ops keep it at its loaded 0.
  assign res_next   = {cell_out, result[WIDTH-1:1]};
  assign carry_next = op_r[2] ? cell_cout : carry;

  // Sequencer FSM with registered busy/done/result/cout/zero; flags are computed
  // from the final-bit values so they are valid in the same cycle as done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      op_r   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      zero   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh   <= a;
            b_sh   <= (op == OP_SUB) ? ~b : b;
            op_r   <= op;
            carry  <= (op == OP_SUB);
            cnt    <= '0;
            result <= '0;
            cout   <= 1'b0;
            zero   <= 1'b0;
            busy   <= 1'b1;
            state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          result <= res_next;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= carry_next;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            cout  <= op_r[2] & carry_next;
            zero  <= (res_next == '0);
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
